// File: rtl/det_pkg.sv
// Shared types and the Sarrus term schedule for the sequential 3x3 determinant engine.
package det_pkg;

    localparam int unsigned NUM_ELEM = 9;
    localparam int unsigned NUM_STEP = 12;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned STEP_W   = 4;
    localparam int unsigned TERM_W   = 3;

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMP,
        S_DONE
    } state_t;

    // Element indices (row-major) of one product term and whether it is subtracted.
    typedef struct packed {
        logic [IDX_W-1:0] x;
        logic [IDX_W-1:0] y;
        logic [IDX_W-1:0] z;
        logic             neg;
    } term_t;

    function automatic term_t term_of(input logic [TERM_W-1:0] t);
        term_t r;
        case (t)
            3'd0:    r = '{x: 4'd0, y: 4'd4, z: 4'd8, neg: 1'b0};
            3'd1:    r = '{x: 4'd1, y: 4'd5, z: 4'd6, neg: 1'b0};
            3'd2:    r = '{x: 4'd2, y: 4'd3, z: 4'd7, neg: 1'b0};
            3'd3:    r = '{x: 4'd2, y: 4'd4, z: 4'd6, neg: 1'b1};
            3'd4:    r = '{x: 4'd0, y: 4'd5, z: 4'd7, neg: 1'b1};
            3'd5:    r = '{x: 4'd1, y: 4'd3, z: 4'd8, neg: 1'b1};
            default: r = '{x: 4'd0, y: 4'd4, z: 4'd8, neg: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/det_mac.sv
// Two-step signed multiply-accumulate: even step latches x*y, odd step adds/subtracts tmp*z.
module det_mac
    import det_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          odd,
    input  logic          neg,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    input  logic [DW-1:0] z,
    output logic [OW-1:0] acc_nxt_c
);

    localparam int unsigned PW = 2 * DW;

    logic [PW-1:0] tmp;
    logic [PW-1:0] prod_xy_c;
    logic [OW-1:0] acc;
    logic [OW-1:0] prod_tz_c;

    // Sign-extended operands; modular low bits of the product are exact at these widths.
    always_comb begin
        prod_xy_c = {{DW{x[DW-1]}}, x} * {{DW{y[DW-1]}}, y};
        prod_tz_c = {{(OW-PW){tmp[PW-1]}}, tmp} * {{(OW-DW){z[DW-1]}}, z};
        acc_nxt_c = acc;
        if (en && odd) begin
            acc_nxt_c = neg ? (acc - prod_tz_c) : (acc + prod_tz_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tmp <= '0;
            acc <= '0;
        end else if (en) begin
            if (!odd) begin
                tmp <= prod_xy_c;
            end else begin
                acc <= acc_nxt_c;
            end
        end
    end

endmodule

// File: rtl/det3_seq.sv
// Sequential 3x3 signed determinant: streams 9 elements in, 12 MAC steps, result out.
// Optional singular flag output when DET_SINGULAR_EN is defined.
module det3_seq
    import det_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          elem_valid,
    output logic          elem_ready,
    input  logic [DW-1:0] elem_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [OW-1:0] res_data,
`ifdef DET_SINGULAR_EN
    output logic          singular,
`endif
    output logic          busy
);

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  count;
    logic [STEP_W-1:0] step;
    logic [DW-1:0]     slot [NUM_ELEM];

    logic              elem_take_c;
    logic              res_take_c;
    logic              mac_en_c;
    logic              mac_clr_c;
    logic              last_step_c;
    term_t             term_c;
    logic [OW-1:0]     acc_nxt_c;

    assign term_c      = term_of(step[STEP_W-1:1]);
    assign last_step_c = (step == STEP_W'(NUM_STEP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake qualifiers; clear overrides every transfer.
    always_comb begin
        state_nxt   = state;
        elem_take_c = 1'b0;
        res_take_c  = 1'b0;
        mac_en_c    = 1'b0;
        mac_clr_c   = 1'b0;
        case (state)
            S_LOAD: begin
                mac_clr_c   = 1'b1;
                elem_take_c = elem_valid && elem_ready;
                if (elem_take_c && (count == IDX_W'(NUM_ELEM - 1))) begin
                    state_nxt = S_COMP;
                end
            end
            S_COMP: begin
                mac_en_c = 1'b1;
                if (last_step_c) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                res_take_c = res_valid && res_ready;
                if (res_take_c) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
        if (clear) begin
            state_nxt   = S_LOAD;
            elem_take_c = 1'b0;
            res_take_c  = 1'b0;
            mac_en_c    = 1'b0;
            mac_clr_c   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (elem_take_c) begin
            slot[count] <= elem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= '0;
            step       <= '0;
            elem_ready <= 1'b0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
`ifdef DET_SINGULAR_EN
            singular   <= 1'b0;
`endif
        end else begin
            elem_ready <= (state_nxt == S_LOAD);
            busy       <= (state_nxt != S_LOAD);
            if (clear) begin
                count     <= '0;
                step      <= '0;
                res_valid <= 1'b0;
`ifdef DET_SINGULAR_EN
                singular  <= 1'b0;
`endif
            end else begin
                if (elem_take_c) begin
                    count <= count + IDX_W'(1);
                end
                if (mac_en_c) begin
                    step <= last_step_c ? '0 : (step + STEP_W'(1));
                    if (last_step_c) begin
                        res_valid <= 1'b1;
                        res_data  <= acc_nxt_c;
`ifdef DET_SINGULAR_EN
                        singular  <= (acc_nxt_c == '0);
`endif
                    end
                end
                if (res_take_c) begin
                    res_valid <= 1'b0;
                    count     <= '0;
`ifdef DET_SINGULAR_EN
                    singular  <= 1'b0;
`endif
                end
            end
        end
    end

    det_mac #(
        .DW (DW),
        .OW (OW)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .clr       (mac_clr_c),
        .en        (mac_en_c),
        .odd       (step[0]),
        .neg       (term_c.neg),
        .x         (slot[term_c.x]),
        .y         (slot[term_c.y]),
        .z         (slot[term_c.z]),
        .acc_nxt_c (acc_nxt_c)
    );

endmodule
